// File: rtl/sar_search_if.sv
// Comparator-side bundle for the successive-approximation search controller.
// master = the search controller, slave = the comparator/requester side.
interface sar_search_if #(
  parameter int W = 4
);
  logic         start;
  logic         gt;
  logic         eq;
  logic         lt;
  logic [W-1:0] guess;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         found;
  logic [W-1:0] steps;
  logic         err;

  modport master (
    input  start, gt, eq, lt,
    output guess, busy, done, result, found, steps, err
  );

  modport slave (
    output start, gt, eq, lt,
    input  guess, busy, done, result, found, steps, err
  );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search controller: drives trial values onto a
// magnitude comparator and recovers the unknown operand one bit per clock.
module sar_search #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  sar_search_if.master bus
);

  localparam int IW = (W > 2) ? $clog2(W) : 1;
  localparam logic [W-1:0]  LP_ONE  = W'(1);
  localparam logic [W-1:0]  LP_ZERO = W'(0);
  localparam logic [IW-1:0] LP_IDX1 = IW'(1);
  localparam logic [IW-1:0] LP_IDXT = IW'(W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t        r_state,  w_state_n;
  logic [W-1:0]  r_guess,  w_guess_n;
  logic [W-1:0]  r_acc,    w_acc_n;
  logic [IW-1:0] r_idx,    w_idx_n;
  logic [W-1:0]  r_result, w_result_n;
  logic [W-1:0]  r_steps,  w_steps_n;
  logic          r_found,  w_found_n;
  logic          r_busy,   w_busy_n;
  logic          r_done,   w_done_n;
  logic          r_err,    w_err_n;

  logic          w_onehot;
  logic [W-1:0]  w_keep;

  // Flag validity: exactly one of gt/eq/lt must be set.
  always_comb begin
    w_onehot = 1'b0;
    case ({bus.gt, bus.eq, bus.lt})
      3'b100, 3'b010, 3'b001: w_onehot = 1'b1;
      default:                w_onehot = 1'b0;
    endcase
  end

  // A gt answer keeps the trial bit (acc takes the guess), lt drops it.
  assign w_keep = bus.gt ? r_guess : r_acc;

  // Next-state and datapath update.
  always_comb begin
    w_state_n  = r_state;
    w_guess_n  = r_guess;
    w_acc_n    = r_acc;
    w_idx_n    = r_idx;
    w_result_n = r_result;
    w_steps_n  = r_steps;
    w_found_n  = r_found;
    w_busy_n   = r_busy;
    w_done_n   = 1'b0;
    w_err_n    = r_err;
    case (r_state)
      ST_IDLE, ST_ERR: begin
        if (bus.start) begin
          w_acc_n   = LP_ZERO;
          w_idx_n   = LP_IDXT;
          w_steps_n = LP_ZERO;
          w_guess_n = LP_ONE << (W - 1);
          w_busy_n  = 1'b1;
          w_err_n   = 1'b0;
          w_state_n = ST_CMP;
        end else begin
          w_state_n = r_state;
        end
      end
      ST_CMP: begin
        if (!w_onehot) begin
          // Malformed flags: keep the previous result/found/steps untouched.
          w_busy_n  = 1'b0;
          w_err_n   = 1'b1;
          w_state_n = ST_ERR;
        end else if (bus.eq) begin
          w_steps_n  = r_steps + LP_ONE;
          w_result_n = r_guess;
          w_found_n  = 1'b1;
          w_done_n   = 1'b1;
          w_busy_n   = 1'b0;
          w_state_n  = ST_IDLE;
        end else if (r_idx == '0) begin
          w_steps_n  = r_steps + LP_ONE;
          w_acc_n    = w_keep;
          w_result_n = w_keep;
          w_found_n  = 1'b0;
          w_done_n   = 1'b1;
          w_busy_n   = 1'b0;
          w_state_n  = ST_IDLE;
        end else begin
          w_steps_n = r_steps + LP_ONE;
          w_acc_n   = w_keep;
          w_guess_n = w_keep | (LP_ONE << (r_idx - LP_IDX1));
          w_idx_n   = r_idx - LP_IDX1;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_guess  <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_result <= '0;
      r_steps  <= '0;
      r_found  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_guess  <= w_guess_n;
      r_acc    <= w_acc_n;
      r_idx    <= w_idx_n;
      r_result <= w_result_n;
      r_steps  <= w_steps_n;
      r_found  <= w_found_n;
      r_busy   <= w_busy_n;
      r_done   <= w_done_n;
      r_err    <= w_err_n;
    end
  end

  assign bus.guess  = r_guess;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.found  = r_found;
  assign bus.steps  = r_steps;
  assign bus.err    = r_err;

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: directed cases plus random unknowns,
// checked against a plain binary-search reference model.
module tb_sar_search;
  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] unknown;
  logic         inject;
  int           n_pass;
  int           n_total;

  sar_search_if #(.W(W)) bus ();

  sar_search #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural comparator; inject forces gt and lt together.
  assign bus.gt = inject ? 1'b1 : (unknown > bus.guess);
  assign bus.eq = inject ? 1'b0 : (unknown == bus.guess);
  assign bus.lt = inject ? 1'b1 : (unknown < bus.guess);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state for the current search.
  int exp_g[$];
  int exp_res;
  int exp_found;
  int exp_steps;

  task automatic chk(input string tag, input int obs, input int expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // Binary search by arithmetic: try each bit from the top, keep it if unknown is larger.
  task automatic model(input int u);
    int acc;
    int g;
    exp_g.delete();
    acc       = 0;
    exp_found = 0;
    exp_res   = -1;
    for (int b = W - 1; b >= 0; b--) begin
      g = acc + (1 << b);
      exp_g.push_back(g);
      if (u == g) begin
        exp_found = 1;
        exp_res   = g;
        break;
      end else if (u > g) begin
        acc = g;
      end
    end
    if (exp_found == 0) exp_res = acc;
    exp_steps = exp_g.size();
  endtask

  // Starts at a negedge, returns at the negedge of the done cycle.
  task automatic do_search(input int u);
    model(u);
    unknown   = u[W-1:0];
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < exp_steps; i++) begin
      chk("busy", int'(bus.busy), 1);
      chk("guess", int'(bus.guess), exp_g[i]);
      chk("done_early", int'(bus.done), 0);
      chk("err_run", int'(bus.err), 0);
      @(negedge clk);
    end
    chk("done", int'(bus.done), 1);
    chk("busy_done", int'(bus.busy), 0);
    chk("result", int'(bus.result), exp_res);
    chk("found", int'(bus.found), exp_found);
    chk("steps", int'(bus.steps), exp_steps);
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("done_pulse", int'(bus.done), 0);
    chk("result_hold", int'(bus.result), exp_res);
    chk("found_hold", int'(bus.found), exp_found);
    chk("steps_hold", int'(bus.steps), exp_steps);
  endtask

  task automatic check_reset_outputs();
    chk("rst_guess", int'(bus.guess), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_found", int'(bus.found), 0);
    chk("rst_steps", int'(bus.steps), 0);
    chk("rst_err", int'(bus.err), 0);
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    inject    = 1'b0;
    unknown   = '0;
    bus.start = 1'b0;
    rst       = 1'b1;
    #2;
    check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_search(5);
    idle_check();
    do_search(8);
    idle_check();
    do_search(0);
    idle_check();
    do_search(15);
    // Back-to-back: start raised in the done cycle.
    do_search(9);
    do_search(6);
    idle_check();

    // Invalid flags on the second compare while searching for 3.
    unknown   = 4'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("err_g0", int'(bus.guess), 8);
    @(negedge clk);
    chk("err_g1", int'(bus.guess), 4);
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    chk("err_set", int'(bus.err), 1);
    chk("err_busy", int'(bus.busy), 0);
    chk("err_done", int'(bus.done), 0);
    @(negedge clk);
    chk("err_hold", int'(bus.err), 1);
    chk("err_nodone", int'(bus.done), 0);
    do_search(3);
    idle_check();

    // Reset during the third compare; start while busy is ignored.
    model(5);
    unknown   = 4'd5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign_start_guess", int'(bus.guess), exp_g[2]);
    chk("ign_start_busy", int'(bus.busy), 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_done", int'(bus.done), 0);
    do_search(5);
    idle_check();

    // Random unknowns.
    for (int n = 0; n < 24; n++) begin
      do_search(int'($urandom_range(0, (1 << W) - 1)));
      if ($urandom_range(0, 1) == 0) idle_check();
    end
    idle_check();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
